sa_edge_feeder: RTL and testbench

//  Upstream stage of the FFN systolic array. Accepts one N-wide A row-slice and one N-wide B

---
 rtl/sa_pkg.sv | 20 ++
 rtl/skew_line.sv | 47 ++++
 rtl/sa_edge_feeder.sv | 127 ++++++++++++
 tb/tb_sa_edge_feeder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array edge feeder.
// Holds the feeder FSM state encoding, the default element width and the lane slicing helper.
// Imported by the feeder top and anything that needs to address lanes of a packed slice.
package sa_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  // Bit offset of lane 'lane' inside a packed N*dw slice (lane 0 in the LSBs).
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line for one edge lane of the systolic array.
// Latency DEPTH cycles; DEPTH=0 is a plain wire.
// No backpressure: shifts every cycle, async reset clears every stage.
module skew_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    // Clock and reset have no load in the zero-depth lane.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_shift
    logic [DATA_WIDTH-1:0] stage_q [DEPTH];
    logic [DATA_WIDTH-1:0] stage_d [DEPTH];

    // Next-state of the shift chain: new value enters stage 0, others move one step.
    always_comb begin
      stage_d[0] = d_i;
      for (int s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end

    // Stage registers; reset drains the lane to zero immediately.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < DEPTH; s++) begin
          stage_q[s] <= '0;
        end
      end else begin
        for (int s = 0; s < DEPTH; s++) begin
          stage_q[s] <= stage_d[s];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/sa_edge_feeder.sv
// Edge feeder for the N x N systolic array: skews A rows / B columns and sequences acc_en per command.
// Lane i of a_o/b_o lags the accepted beat by i+1 cycles; done follows the last beat by 2*N-1 flush cycles.
// in_ready is high only while streaming; idle cycles inside a stream inject zeros into the lanes.
module sa_edge_feeder
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = 4,
  parameter int K_MAX      = 256,
  parameter int CNT_WIDTH  = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  output logic [N*DATA_WIDTH-1:0] a_o,
  output logic [N*DATA_WIDTH-1:0] b_o,
  output logic                    acc_en_o,
  output logic                    busy,
  output logic                    done
);

  // Skew across the edge plus hops across the grid plus the mac stage.
  localparam int FLUSH_CYC = 2 * N - 1;
  localparam int FCW       = $clog2(FLUSH_CYC + 1);

  feeder_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]   klen_q, klen_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FCW-1:0]         flush_cnt_q, flush_cnt_d;
  logic                   acc_en_q, acc_en_d;
  logic [N*DATA_WIDTH-1:0] entry_a_q, entry_a_d;
  logic [N*DATA_WIDTH-1:0] entry_b_q, entry_b_d;
  logic [CNT_WIDTH-1:0]   k_len_sat;
  logic                   beat_acc;

  assign in_ready = (state_q == STREAM);
  assign busy     = (state_q == STREAM) || (state_q == FLUSH);
  assign done     = (state_q == DONE);
  assign acc_en_o = acc_en_q;
  assign beat_acc = in_valid && in_ready;

  // Command sequencing: beat counting in STREAM, fixed-length drain in FLUSH.
  always_comb begin
    state_d     = state_q;
    klen_d      = klen_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    k_len_sat   = (k_len > CNT_WIDTH'(K_MAX)) ? CNT_WIDTH'(K_MAX) : k_len;
    case (state_q)
      IDLE: begin
        if (start) begin
          klen_d      = k_len_sat;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = (k_len_sat == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          if (beat_cnt_d == klen_q) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FCW'(1);
        if (flush_cnt_q == FCW'(FLUSH_CYC - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    acc_en_d  = (state_d == STREAM) || (state_d == FLUSH);
    entry_a_d = beat_acc ? in_a : '0;
    entry_b_d = beat_acc ? in_b : '0;
  end

  // Control and entry-stage registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      klen_q      <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      acc_en_q    <= 1'b0;
      entry_a_q   <= '0;
      entry_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      acc_en_q    <= acc_en_d;
      entry_a_q   <= entry_a_d;
      entry_b_q   <= entry_b_d;
    end
  end

  // Lane i gets i extra stages so element k reaches pe[i][j] in step with its partner.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i)) u_skew_a (
      .clk (clk),
      .rst (rst),
      .d_i (entry_a_q[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .q_o (a_o[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i)) u_skew_b (
      .clk (clk),
      .rst (rst),
      .d_i (entry_b_q[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .q_o (b_o[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Bench for sa_edge_feeder: per-cycle vector table, lane delay scoreboard and an N x N pe grid model.
module tb_sa_edge_feeder;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int KM = 256;
  localparam int CW = 9;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_a = '0;
  logic [VW-1:0] in_b = '0;
  logic          in_ready, acc_en_o, busy, done;
  logic [VW-1:0] a_o, b_o;

  always #5 clk = ~clk;

  sa_edge_feeder #(.DATA_WIDTH(DW), .N(N), .K_MAX(KM), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .a_o(a_o), .b_o(b_o), .acc_en_o(acc_en_o), .busy(busy), .done(done)
  );

  typedef struct {
    logic          start;
    logic [CW-1:0] k_len;
    logic          in_valid;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic          rdy;
    logic          bsy;
    logic          acc;
    logic          dn;
  } vec_t;

  vec_t            tbl[$];
  logic [2*VW-1:0] sb[$];
  longint          exp_c[N][N];
  int              n_chk = 0;
  int              n_fail = 0;
  int              n_done = 0;

  // ---------------- pe grid model driven by the DUT edges ----------------
  logic                 grid_clr = 1'b0;
  logic signed [DW-1:0] ga_q[N][N];
  logic signed [DW-1:0] gb_q[N][N];
  longint               gacc[N][N];

  function automatic logic signed [DW-1:0] pe_a(input int i, input int j);
    if (j == 0) return a_o[i*DW +: DW];
    return ga_q[i][j-1];
  endfunction

  function automatic logic signed [DW-1:0] pe_b(input int i, input int j);
    if (i == 0) return b_o[j*DW +: DW];
    return gb_q[i-1][j];
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ga_q[i][j] <= pe_a(i, j);
        gb_q[i][j] <= pe_b(i, j);
        if (grid_clr)
          gacc[i][j] <= 0;
        else if (acc_en_o)
          gacc[i][j] <= gacc[i][j] + longint'(pe_a(i, j)) * longint'(pe_b(i, j));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [VW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    logic [VW-1:0] v;
    v[0*DW +: DW] = 16'(l0);
    v[1*DW +: DW] = 16'(l1);
    v[2*DW +: DW] = 16'(l2);
    v[3*DW +: DW] = 16'(l3);
    return v;
  endfunction

  function automatic vec_t mk(input logic s, input int k, input logic v, input logic [VW-1:0] a,
                              input logic [VW-1:0] b, input logic rdy, input logic bsy,
                              input logic acc, input logic dn);
    vec_t r;
    r.start = s; r.k_len = CW'(k); r.in_valid = v; r.a = a; r.b = b;
    r.rdy = rdy; r.bsy = bsy; r.acc = acc; r.dn = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " a_o"}, 64'(a_o), 64'(0));
    chk({nm, " b_o"}, 64'(b_o), 64'(0));
    chk({nm, " in_ready"}, 64'(in_ready), 64'(0));
    chk({nm, " busy"}, 64'(busy), 64'(0));
    chk({nm, " acc_en"}, 64'(acc_en_o), 64'(0));
    chk({nm, " done"}, 64'(done), 64'(0));
  endtask

  task automatic model_acc(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic signed [DW-1:0] x, y;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        x = a[i*DW +: DW];
        y = b[j*DW +: DW];
        exp_c[i][j] += longint'(x) * longint'(y);
      end
    end
  endtask

  // Called at posedge+1: drive one row, predict the entry value, check at the negedge.
  task automatic apply(input vec_t r, input string nm);
    logic [2*VW-1:0] e;
    logic [2*VW-1:0] src;
    logic [VW-1:0]   ea, eb;
    start = r.start; k_len = r.k_len; in_valid = r.in_valid; in_a = r.a; in_b = r.b;
    e = '0;
    if (r.in_valid && r.rdy) begin
      e = {r.a, r.b};
      model_acc(r.a, r.b);
    end
    sb.push_front(e);
    if (sb.size() > N + 1) void'(sb.pop_back());
    @(negedge clk);
    chk({nm, " in_ready"}, 64'(in_ready), 64'(r.rdy));
    chk({nm, " busy"}, 64'(busy), 64'(r.bsy));
    chk({nm, " acc_en"}, 64'(acc_en_o), 64'(r.acc));
    chk({nm, " done"}, 64'(done), 64'(r.dn));
    if (done === 1'b1) n_done++;
    for (int i = 0; i < N; i++) begin
      src = (i + 1 < sb.size()) ? sb[i+1] : '0;
      ea[i*DW +: DW] = src[VW + i*DW +: DW];
      eb[i*DW +: DW] = src[i*DW +: DW];
    end
    chk({nm, " a_o"}, 64'(a_o), 64'(ea));
    chk({nm, " b_o"}, 64'(b_o), 64'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_row(input string nm);
    apply(mk(0, 0, 0, '0, '0, 0, 0, 0, 0), nm);
  endtask

  task automatic grid_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_c[i][j] = 0;
    grid_clr = 1'b1;
    idle_row("clr");
    grid_clr = 1'b0;
  endtask

  task automatic check_grid(input string nm);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s C[%0d][%0d]", nm, i, j), 64'(gacc[i][j]), 64'(exp_c[i][j]));
  endtask

  task automatic run(input int first, input int last, input string nm);
    for (int k = first; k < last; k++) apply(tbl[k], $sformatf("%s r%0d", nm, k - first));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [VW-1:0] pa, pb;
    int e2, e3, e4, e6, e7;

    // Vector table: test 2 (basic), 3 (stalls), 4 (k_len=0), 6 (start ignored), saturation.
    pa = pack(1, 2, 3, 4);
    pb = pack(10, 20, 30, 40);
    tbl.push_back(mk(1, 3, 1, pa, pb, 0, 0, 0, 0));
    repeat (3) tbl.push_back(mk(0, 0, 1, pa, pb, 1, 1, 1, 0));
    repeat (7) tbl.push_back(mk(0, 0, 1, pa, pb, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, pa, pb, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 0));
    e2 = tbl.size();

    tbl.push_back(mk(1, 2, 0, '0, '0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, pack(3, -2, 5, 7), pack(-4, 6, 1, 2), 1, 1, 1, 0));
    repeat (2) tbl.push_back(mk(0, 0, 0, pack(99, 99, 99, 99), pack(99, 99, 99, 99), 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, pack(-1, 8, -3, 2), pack(5, -7, 9, -6), 1, 1, 1, 0));
    repeat (7) tbl.push_back(mk(0, 0, 0, '0, '0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 0));
    e3 = tbl.size();

    tbl.push_back(mk(1, 0, 1, pa, pb, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, pa, pb, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 0));
    e4 = tbl.size();

    tbl.push_back(mk(1, 2, 0, '0, '0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1, pack(2, -3, 4, 6), pack(7, 1, -2, 5), 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, pack(-5, 1, 2, -8), pack(3, -4, 6, 2), 1, 1, 1, 0));
    repeat (7) tbl.push_back(mk(1, 7, 1, pack(9, 9, 9, 9), pack(9, 9, 9, 9), 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 1));
    repeat (2) tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 0));
    e6 = tbl.size();

    tbl.push_back(mk(1, 300, 0, '0, '0, 0, 0, 0, 0));
    for (int b = 0; b < KM; b++)
      tbl.push_back(mk(0, 0, 1, pack(b, b + 1, -b, 3), pack(2, -b, b + 7, 1), 1, 1, 1, 0));
    repeat (7) tbl.push_back(mk(0, 0, 1, pack(1, 1, 1, 1), pack(1, 1, 1, 1), 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, 0));
    e7 = tbl.size();

    // Test 1: reset held 3 cycles, then 5 idle cycles.
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset");
    end
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    repeat (5) idle_row("post-reset idle");

    grid_reset();
    run(0, e2, "t2");
    check_grid("t2");

    grid_reset();
    run(e2, e3, "t3");
    check_grid("t3");

    n_done = 0;
    run(e3, e4, "t4");
    chk("t4 done count", 64'(n_done), 64'(1));

    grid_reset();
    n_done = 0;
    run(e4, e6, "t6");
    chk("t6 done count", 64'(n_done), 64'(1));
    check_grid("t6");

    grid_reset();
    run(e6, e7, "sat");
    check_grid("sat");

    // Test 5: reset during FLUSH aborts with no done; a fresh k_len=1 command then completes.
    apply(mk(1, 2, 1, pa, pb, 0, 0, 0, 0), "t5 start");
    apply(mk(0, 0, 1, pack(4, 3, 2, 1), pb, 1, 1, 1, 0), "t5 beat1");
    apply(mk(0, 0, 1, pa, pack(-1, -2, -3, -4), 1, 1, 1, 0), "t5 beat2");
    apply(mk(0, 0, 0, '0, '0, 0, 1, 1, 0), "t5 flush0");
    apply(mk(0, 0, 0, '0, '0, 0, 1, 1, 0), "t5 flush1");
    #2 rst = 1'b1;
    #1;
    chk_zero("t5 async reset");
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    n_done = 0;
    repeat (10) idle_row("t5 after abort");
    chk("t5 no done after abort", 64'(n_done), 64'(0));

    grid_reset();
    n_done = 0;
    apply(mk(1, 1, 0, '0, '0, 0, 0, 0, 0), "t5 restart");
    apply(mk(0, 0, 1, pack(-7, 5, 11, -2), pack(3, -9, 4, 8), 1, 1, 1, 0), "t5 rbeat");
    for (int f = 0; f < 7; f++) apply(mk(0, 0, 0, '0, '0, 0, 1, 1, 0), $sformatf("t5 rflush%0d", f));
    apply(mk(0, 0, 0, '0, '0, 0, 0, 0, 1), "t5 rdone");
    idle_row("t5 ridle");
    chk("t5 restart done count", 64'(n_done), 64'(1));
    check_grid("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
